// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   Round-robin arbiter sharing one single-address memory read port among
//   NUM_REQ requesters. One transaction is outstanding at a time. A watchdog
//   aborts a grant that waits TIMEOUT cycles for mem_resp (0 disables it).
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_read_i      per-requester read request level
//   req_addr_i      packed requester addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_resp_o      one-cycle response pulse to the granted requester
//   req_rdata_o     read data broadcast (valid with req_resp_o)
//   mem_read        memory read strobe
//   mem_addr        memory address
//   mem_resp        memory response pulse
//   mem_rdata       memory read data
//   grant_o         one-hot current grant, zero when idle
//   busy_o          transaction in flight
//   timeout_o       one-cycle pulse when the watchdog aborts a transaction
module mem_read_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_read_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]              req_resp_o,
    output logic [DATA_WIDTH-1:0]           req_rdata_o,
    output logic                            mem_read,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic                            mem_resp,
    input  logic [DATA_WIDTH-1:0]           mem_rdata,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            busy_o,
    output logic                            timeout_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    // TIMEOUT-1 underflows when the watchdog is disabled; the value is then unused.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                  state_q,   state_d;
    logic [IDX_W-1:0]        rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0]        gnt_idx_q, gnt_idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;

    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [IDX_W-1:0]        next_ptr;
    logic [NUM_REQ-1:0]      gnt_vec;
    logic                    timeout_hit;

    // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin : rr_search
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!sel_found && req_read_i[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign sel_addr    = req_addr_i[32'(sel_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign next_ptr    = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
    assign gnt_vec     = NUM_REQ'(1) << gnt_idx_q;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign req_rdata_o = mem_rdata;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_idx_d  = gnt_idx_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        mem_read   = 1'b0;
        mem_addr   = '0;
        grant_o    = '0;
        busy_o     = 1'b0;
        req_resp_o = '0;
        timeout_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d   = GRANT;
                    gnt_idx_d = sel_idx;
                    addr_d    = sel_addr;
                    cnt_d     = '0;
                end
            end
            GRANT: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                grant_o  = gnt_vec;
                busy_o   = 1'b1;
                // A response on the watchdog's final cycle still completes normally.
                if (mem_resp) begin
                    req_resp_o = gnt_vec;
                    state_d    = IDLE;
                    rr_ptr_d   = next_ptr;
                end else if (timeout_hit) begin
                    timeout_o = 1'b1;
                    state_d   = IDLE;
                    rr_ptr_d  = next_ptr;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter
//   Directed bench for mem_read_arbiter (NUM_REQ=4, 32-bit address/data,
//   TIMEOUT=8). Stimulus pushes expected grants and responses into queues;
//   a negedge monitor pops and compares whenever mem_read rises or a
//   response/timeout pulse appears.
module tb_mem_read_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_read_i = '0;
    logic [NR*AW-1:0]  req_addr_i = '0;
    logic [NR-1:0]     req_resp_o;
    logic [DW-1:0]     req_rdata_o;
    logic              mem_read;
    logic [AW-1:0]     mem_addr;
    logic              mem_resp = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;
    logic [NR-1:0]     grant_o;
    logic              busy_o;
    logic              timeout_o;

    mem_read_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_read_i  (req_read_i),
        .req_addr_i  (req_addr_i),
        .req_resp_o  (req_resp_o),
        .req_rdata_o (req_rdata_o),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] grant;
        logic [AW-1:0] addr;
        int            gap;   // cycles since previous mem_read rise; 0 = unchecked
    } grant_exp_t;

    typedef struct {
        logic [NR-1:0] resp;
        logic          to;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        int            off;   // cycles after the mem_read rise of this grant
    } resp_exp_t;

    grant_exp_t grant_q[$];
    resp_exp_t  resp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   last_rise = 0;
    logic prev_mr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_addr(input int idx, input logic [AW-1:0] a);
        req_addr_i[idx*AW +: AW] = a;
    endtask

    task automatic push_grant(input logic [NR-1:0] g, input logic [AW-1:0] a, input int gap);
        grant_exp_t e;
        e.grant = g;
        e.addr  = a;
        e.gap   = gap;
        grant_q.push_back(e);
    endtask

    task automatic push_resp(input logic [NR-1:0] r, input logic to, input logic [DW-1:0] d,
                             input logic [AW-1:0] a, input int off);
        resp_exp_t e;
        e.resp = r;
        e.to   = to;
        e.data = d;
        e.addr = a;
        e.off  = off;
        resp_q.push_back(e);
    endtask

    task automatic wait_mem_read(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_read) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: mem_read=0 after 40 cycles, required 1", name);
    endtask

    task automatic wait_timeout(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (timeout_o) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout_o=0 after 20 cycles, required 1", name);
    endtask

    // Pulse mem_resp `delay` posedges from now, then drop the served requester.
    task automatic do_resp(input int delay, input logic [DW-1:0] data, input logic [NR-1:0] mask);
        repeat (delay) @(posedge clk);
        #1;
        mem_resp  = 1'b1;
        mem_rdata = data;
        @(posedge clk);
        #1;
        mem_resp   = 1'b0;
        req_read_i = req_read_i & ~mask;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Monitor: compares every grant start and every response/timeout pulse.
    initial begin
        grant_exp_t g;
        resp_exp_t  r;
        forever begin
            @(negedge clk);
            if (mem_read && !prev_mr) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: got grant_o=%b, required no grant", grant_o);
                end else begin
                    g = grant_q.pop_front();
                    chk("grant_o", 64'(grant_o), 64'(g.grant));
                    chk("grant_addr", 64'(mem_addr), 64'(g.addr));
                    chk("grant_busy", 64'(busy_o), 64'(1));
                    if (g.gap != 0) chk("grant_gap", 64'(cycle - last_rise), 64'(g.gap));
                end
                last_rise = cycle;
            end
            if (req_resp_o != '0 || timeout_o) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got req_resp_o=%b timeout_o=%b, required none",
                             req_resp_o, timeout_o);
                end else begin
                    r = resp_q.pop_front();
                    chk("req_resp_o", 64'(req_resp_o), 64'(r.resp));
                    chk("timeout_o", 64'(timeout_o), 64'(r.to));
                    if (!r.to) chk("req_rdata_o", 64'(req_rdata_o), 64'(r.data));
                    chk("resp_addr", 64'(mem_addr), 64'(r.addr));
                    chk("resp_offset", 64'(cycle - last_rise), 64'(r.off));
                end
            end
            prev_mr = mem_read;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        mem_rdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_read", 64'(mem_read), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_resp", 64'(req_resp_o), 64'(0));
        chk("rst_timeout", 64'(timeout_o), 64'(0));
        chk("rst_rdata_pass", 64'(req_rdata_o), 64'h1234_5678);
        mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("rst_rdata_pass2", 64'(req_rdata_o), 64'hCAFE_F00D);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single request from requester 2, response 3 cycles after mem_read rises
        set_addr(2, 32'h40);
        push_grant(4'b0100, 32'h40, 0);
        push_resp(4'b0100, 1'b0, 32'hDEAD, 32'h40, 3);
        req_read_i = 4'b0100;
        wait_mem_read("t1_grant");
        do_resp(3, 32'hDEAD, 4'b0100);

        // rr_ptr is now 3: with 0 and 3 requesting, 3 wins
        set_addr(0, 32'h50);
        set_addr(3, 32'h58);
        push_grant(4'b1000, 32'h58, 0);
        push_resp(4'b1000, 1'b0, 32'h5858, 32'h58, 1);
        req_read_i = 4'b1001;
        wait_mem_read("rr3_grant");
        do_resp(1, 32'h5858, 4'b1001);

        // All four requesting, memory answers 1 cycle after mem_read: 0,1,2,3,0,1
        for (int i = 0; i < 4; i++) set_addr(i, 32'h1000 + 32'(i) * 32'h10);
        for (int n = 0; n < 6; n++) begin
            push_grant(4'b0001 << (n % 4), 32'h1000 + 32'(n % 4) * 32'h10, (n == 0) ? 0 : 3);
            push_resp(4'b0001 << (n % 4), 1'b0, 32'hA000 + 32'(n),
                      32'h1000 + 32'(n % 4) * 32'h10, 1);
        end
        req_read_i = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            wait_mem_read("rr_seq_grant");
            do_resp(1, 32'hA000 + 32'(n), (n == 5) ? 4'b1111 : 4'b0000);
        end

        // Address change mid-GRANT is ignored (rr_ptr=2, only requester 1)
        set_addr(1, 32'h100);
        push_grant(4'b0010, 32'h100, 0);
        push_resp(4'b0010, 1'b0, 32'hB100, 32'h100, 3);
        req_read_i = 4'b0010;
        wait_mem_read("freeze_grant");
        @(posedge clk);
        #1;
        set_addr(1, 32'h200);
        @(negedge clk);
        chk("addr_frozen", 64'(mem_addr), 64'h100);
        do_resp(2, 32'hB100, 4'b0010);

        // Timeout on requester 2 at its 8th GRANT cycle, then 3, then 2 again
        set_addr(2, 32'h300);
        set_addr(3, 32'h380);
        push_grant(4'b0100, 32'h300, 0);
        push_resp(4'b0000, 1'b1, 32'h0, 32'h300, 7);
        push_grant(4'b1000, 32'h380, 9);
        push_resp(4'b1000, 1'b0, 32'hB3, 32'h380, 1);
        push_grant(4'b0100, 32'h300, 3);
        push_resp(4'b0100, 1'b0, 32'hB2, 32'h300, 1);
        req_read_i = 4'b1100;
        wait_mem_read("to_grant");
        wait_timeout("to_pulse");
        @(posedge clk);
        #1;
        wait_mem_read("after_to_grant");
        do_resp(1, 32'hB3, 4'b1000);
        wait_mem_read("regrant_2");
        do_resp(1, 32'hB2, 4'b0100);

        // Response on the exact timeout cycle (cnt=7) wins (rr_ptr=3, requester 0)
        set_addr(0, 32'h600);
        push_grant(4'b0001, 32'h600, 0);
        push_resp(4'b0001, 1'b0, 32'hC6, 32'h600, 7);
        req_read_i = 4'b0001;
        wait_mem_read("edge_grant");
        do_resp(7, 32'hC6, 4'b0001);

        // mem_resp while IDLE is ignored
        @(posedge clk);
        #1;
        mem_resp  = 1'b1;
        mem_rdata = 32'hEEEE;
        @(negedge clk);
        chk("idle_resp_ignored", 64'(req_resp_o), 64'(0));
        chk("idle_busy", 64'(busy_o), 64'(0));
        @(posedge clk);
        #1;
        mem_resp = 1'b0;

        // Reset mid-GRANT clears outputs immediately; later mem_resp ignored
        set_addr(1, 32'h700);
        push_grant(4'b0010, 32'h700, 0);
        req_read_i = 4'b0010;
        wait_mem_read("rst_mid_grant");
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_mem_read", 64'(mem_read), 64'(0));
        chk("async_rst_grant", 64'(grant_o), 64'(0));
        chk("async_rst_busy", 64'(busy_o), 64'(0));
        chk("async_rst_addr", 64'(mem_addr), 64'(0));
        req_read_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_resp = 1'b1;
        @(negedge clk);
        chk("post_rst_resp", 64'(req_resp_o), 64'(0));
        chk("post_rst_mem_read", 64'(mem_read), 64'(0));
        @(posedge clk);
        #1;
        mem_resp = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("grant_q_drained", 64'(grant_q.size()), 64'(0));
        chk("resp_q_drained", 64'(resp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
